// File: rtl/mmio_uart_tx_if.sv
// Data-memory port bundle between the core's memory
// controller and the memory-mapped UART transmitter.
interface mmio_uart_tx_if;
  logic        ram_r;
  logic [3:0]  ram_w;
  logic [31:0] ram_addr;
  logic [31:0] ram_out;
  logic [31:0] rd_data;
  logic        sel;

  modport master (
    output ram_r,
    output ram_w,
    output ram_addr,
    output ram_out,
    input  rd_data,
    input  sel
  );

  modport slave (
    input  ram_r,
    input  ram_w,
    input  ram_addr,
    input  ram_out,
    output rd_data,
    output sel
  );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO,
// sticky overflow flag, enable and flush controls.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
  parameter int          CLK_DIV    = 434,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  mmio_uart_tx_if.slave  bus,
  output logic           tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);
  localparam logic [PW-1:0] FULL_CNT = PW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e        state_q;
  logic [15:0]   baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q;

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic          ovf_q, ovf_d;
  logic          en_q, en_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic          hit;
  logic [1:0]    idx;
  logic          wr;
  logic          wr_tx, wr_st, wr_ct;
  logic          flush;
  logic          push, pop;
  logic [PW-1:0] cnt;
  logic          full, empty;
  logic          busy;
  logic          bit_end;
  logic [31:0]   reg_val;
  logic          unused_ok;

  assign hit   = bus.ram_addr[31:4] == BASE_ADDR[31:4];
  assign idx   = bus.ram_addr[3:2];
  assign wr    = hit & bus.ram_w[0];
  assign wr_tx = wr & (idx == 2'd0);
  assign wr_st = wr & (idx == 2'd1);
  assign wr_ct = wr & (idx == 2'd2);
  assign flush = wr_ct & bus.ram_out[1];

  assign cnt   = wptr_q - rptr_q;
  assign full  = cnt == FULL_CNT;
  assign empty = cnt == '0;
  assign busy  = state_q != IDLE;

  // Fullness is judged before the edge, so a same-edge pop
  // never rescues a write to a full FIFO.
  assign push  = wr_tx & ~full & ~flush;
  assign pop   = (state_q == IDLE) & en_q & ~empty;

  assign bit_end = baud_q == DIV_M1;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    ovf_d  = ovf_q;
    en_d   = en_q;
    if (push)
      wptr_d = wptr_q + PW'(1);
    if (flush)
      rptr_d = wptr_q;
    else if (pop)
      rptr_d = rptr_q + PW'(1);
    if (wr_tx & full)
      ovf_d = 1'b1;
    else if (wr_st & bus.ram_out[3])
      ovf_d = 1'b0;
    if (wr_ct)
      en_d = bus.ram_out[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
      en_q   <= 1'b1;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
      en_q   <= en_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wptr_q[AW-1:0]] <= bus.ram_out[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            shift_q <= mem_q[rptr_q[AW-1:0]];
            baud_q  <= '0;
            tx_q    <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end else begin
            baud_q  <= baud_q + 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              shift_q <= shift_q >> 1;
              bit_q   <= bit_q + 3'd1;
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_q  <= '0;
            tx_q    <= 1'b1;
            state_q <= IDLE;
          end else begin
            baud_q  <= baud_q + 16'd1;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    reg_val = '0;
    unique case (1'b1)
      idx == 2'd1: begin
        reg_val[15:8] = 8'(cnt);
        reg_val[3]    = ovf_q;
        reg_val[2]    = busy;
        reg_val[1]    = empty;
        reg_val[0]    = full;
      end
      idx == 2'd2: reg_val[0] = en_q;
      idx == 2'd0: reg_val = '0;
      idx == 2'd3: reg_val = '0;
      default:     reg_val = '0;
    endcase
  end

  assign bus.sel     = hit;
  assign bus.rd_data = (hit & bus.ram_r) ? reg_val : 32'h0;
  assign tx          = tx_q;

  assign unused_ok = ^{bus.ram_w[3:1], bus.ram_out[31:8],
                       bus.ram_addr[1:0]};

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: queue-based FIFO/flag model and
// bit-time waveform model of 8N1 frames at CLK_DIV=4.
module tb_mmio_uart_tx;
  localparam logic [31:0] BASE  = 32'hFFFF_0000;
  localparam logic [31:0] A_TX  = BASE;
  localparam logic [31:0] A_ST  = BASE + 32'h4;
  localparam logic [31:0] A_CT  = BASE + 32'h8;
  localparam logic [31:0] A_RSV = BASE + 32'hC;
  localparam int DIV   = 4;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx;
  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];
  bit ovf_m;

  mmio_uart_tx_if bus();

  mmio_uart_tx #(
    .BASE_ADDR (BASE),
    .CLK_DIV   (DIV),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave),
    .tx   (tx)
  );

  always #5 clk = ~clk;

  // Line level seen k cycles after the start bit begins.
  function automatic logic [39:0] frame(input logic [7:0] b);
    logic [39:0] f;
    for (int k = 0; k < 40; k++) begin
      int s;
      s = k / DIV;
      if (s == 0) f[k] = 1'b0;
      else if (s <= 8) f[k] = b[s-1];
      else f[k] = 1'b1;
    end
    return f;
  endfunction

  function automatic logic [31:0] st_exp(input int cnt, input bit ovf,
                                         input bit bsy);
    logic [31:0] v;
    v = 32'h0;
    v[15:8] = 8'(cnt);
    v[3] = ovf;
    v[2] = bsy;
    v[1] = (cnt == 0);
    v[0] = (cnt == DEPTH);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] w);
    @(negedge clk);
    bus.ram_addr = a;
    bus.ram_out  = d;
    bus.ram_w    = w;
    @(posedge clk);
    #1;
    bus.ram_w    = 4'h0;
    bus.ram_addr = 32'h0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    bus.ram_addr = a;
    bus.ram_r    = 1'b1;
    #1;
    v = bus.rd_data;
    bus.ram_r    = 1'b0;
    bus.ram_addr = 32'h0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    q.delete();
    ovf_m = 1'b0;
    checks++;
    if (tx !== 1'b1) begin
      errors++;
      $display("FAIL reset_tx got %b want 1", tx);
    end
    rd(A_ST, v);
    checks++;
    if (v !== st_exp(0, 0, 0)) begin
      errors++;
      $display("FAIL reset_status got %h want %h", v, st_exp(0, 0, 0));
    end
    rd(A_CT, v);
    checks++;
    if (v !== 32'h1) begin
      errors++;
      $display("FAIL reset_ctrl got %h want 1", v);
    end
    bus.ram_addr = A_ST;
    #1;
    checks++;
    if (bus.sel !== 1'b1) begin
      errors++;
      $display("FAIL sel_hit got %b want 1", bus.sel);
    end
    bus.ram_addr = BASE + 32'h10;
    #1;
    checks++;
    if (bus.sel !== 1'b0) begin
      errors++;
      $display("FAIL sel_miss got %b want 0", bus.sel);
    end
    bus.ram_addr = 32'h0;
  endtask

  task automatic test_lane_miss();
    logic [31:0] v;
    wr(A_CT, 32'h0, 4'b0001);
    wr(A_TX, 32'hAB, 4'b0010);
    rd(A_ST, v);
    checks++;
    if (v !== st_exp(0, 0, 0)) begin
      errors++;
      $display("FAIL lane_ignore got %h want %h", v, st_exp(0, 0, 0));
    end
    wr(BASE + 32'h10, 32'hAB, 4'b0001);
    rd(A_ST, v);
    checks++;
    if (v !== st_exp(0, 0, 0)) begin
      errors++;
      $display("FAIL addr_miss got %h want %h", v, st_exp(0, 0, 0));
    end
    wr(A_RSV, 32'hFFFF_FFFF, 4'b1111);
    rd(A_RSV, v);
    checks++;
    if (v !== 32'h0) begin
      errors++;
      $display("FAIL rsv_read got %h want 0", v);
    end
    rd(A_TX, v);
    checks++;
    if (v !== 32'h0) begin
      errors++;
      $display("FAIL txdata_read got %h want 0", v);
    end
    bus.ram_addr = A_ST;
    bus.ram_r = 1'b0;
    #1;
    checks++;
    if (bus.rd_data !== 32'h0) begin
      errors++;
      $display("FAIL no_strobe_read got %h want 0", bus.rd_data);
    end
    bus.ram_addr = 32'h0;
    wr(A_CT, 32'h1, 4'b0001);
  endtask

  task automatic test_single();
    logic [31:0] v;
    logic [39:0] act;
    logic [7:0] b;
    for (int n = 0; n < 4; n++) begin
      b = (n == 0) ? 8'h55 : 8'($urandom);
      wr(A_TX, {24'h0, b}, 4'b0001);
      for (int j = 0; j < 40; j++) begin
        step();
        act[j] = tx;
        if (j == 0 || j == 39) begin
          rd(A_ST, v);
          checks++;
          if (v !== st_exp(0, 0, 1)) begin
            errors++;
            $display("FAIL single_busy j=%0d got %h want %h",
                     j, v, st_exp(0, 0, 1));
          end
        end
      end
      checks++;
      if (act !== frame(b)) begin
        errors++;
        $display("FAIL single_frame b=%h got %h want %h",
                 b, act, frame(b));
      end
      step();
      rd(A_ST, v);
      checks++;
      if (v !== st_exp(0, 0, 0) || tx !== 1'b1) begin
        errors++;
        $display("FAIL single_end status %h tx %b want %h tx 1",
                 v, tx, st_exp(0, 0, 0));
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] v;
    wr(A_CT, 32'h0, 4'b0001);
    for (int i = 1; i <= 9; i++) begin
      wr(A_TX, 32'(i), 4'b0001);
      if (q.size() == DEPTH) ovf_m = 1'b1;
      else q.push_back(8'(i));
    end
    rd(A_ST, v);
    checks++;
    if (v !== st_exp(q.size(), ovf_m, 0)) begin
      errors++;
      $display("FAIL ovf_status got %h want %h",
               v, st_exp(q.size(), ovf_m, 0));
    end
    wr(A_ST, 32'h0000_0007, 4'b0001);
    rd(A_ST, v);
    checks++;
    if (v !== st_exp(q.size(), ovf_m, 0)) begin
      errors++;
      $display("FAIL ovf_noclear got %h want %h",
               v, st_exp(q.size(), ovf_m, 0));
    end
    wr(A_ST, 32'h0000_0008, 4'b0001);
    ovf_m = 1'b0;
    rd(A_ST, v);
    checks++;
    if (v !== st_exp(q.size(), ovf_m, 0)) begin
      errors++;
      $display("FAIL ovf_w1c got %h want %h",
               v, st_exp(q.size(), ovf_m, 0));
    end
  endtask

  task automatic test_drain();
    logic [31:0] v;
    logic [40:0] act, exp;
    int nfr;
    wr(A_CT, 32'h1, 4'b0001);
    nfr = q.size();
    for (int f = 0; f < nfr; f++) begin
      exp = {1'b1, frame(q[0])};
      for (int j = 0; j < 41; j++) begin
        step();
        act[j] = tx;
      end
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL drain_frame %0d got %h want %h", f, act, exp);
      end
      void'(q.pop_front());
    end
    act = '1;
    for (int j = 0; j < 41; j++) begin
      step();
      act[j] = tx;
    end
    checks++;
    if (act !== 41'h1FF_FFFF_FFFF) begin
      errors++;
      $display("FAIL drain_idle got %h want all ones", act);
    end
    rd(A_ST, v);
    checks++;
    if (v !== st_exp(0, 0, 0)) begin
      errors++;
      $display("FAIL drain_status got %h want %h", v, st_exp(0, 0, 0));
    end
  endtask

  task automatic test_status_random();
    logic [31:0] v;
    logic [31:0] d;
    int op;
    wr(A_CT, 32'h0, 4'b0001);
    for (int i = 0; i < 30; i++) begin
      op = int'($urandom_range(0, 6));
      d = $urandom;
      if (op <= 3) begin
        wr(A_TX, d, 4'b0001);
        if (q.size() == DEPTH) ovf_m = 1'b1;
        else q.push_back(d[7:0]);
      end else if (op == 4) begin
        wr(A_ST, d, 4'b0001);
        if (d[3]) ovf_m = 1'b0;
      end else if (op == 5) begin
        wr(A_CT, 32'h2, 4'b0001);
        q.delete();
      end else begin
        rd(A_CT, v);
        checks++;
        if (v !== 32'h0) begin
          errors++;
          $display("FAIL rand_ctrl got %h want 0", v);
        end
      end
      rd(A_ST, v);
      checks++;
      if (v !== st_exp(q.size(), ovf_m, 0)) begin
        errors++;
        $display("FAIL rand_status i=%0d got %h want %h",
                 i, v, st_exp(q.size(), ovf_m, 0));
      end
    end
    wr(A_CT, 32'h2, 4'b0001);
    wr(A_ST, 32'h8, 4'b0001);
    q.delete();
    ovf_m = 1'b0;
    wr(A_CT, 32'h1, 4'b0001);
  endtask

  task automatic test_flush_mid();
    logic [31:0] v;
    logic [39:0] act, exp;
    logic [7:0] a;
    logic [60:0] idle;
    a = 8'($urandom);
    exp = frame(a);
    act = '0;
    wr(A_TX, {24'h0, a}, 4'b0001);
    wr(A_TX, $urandom, 4'b0001);
    wr(A_TX, $urandom, 4'b0001);
    wr(A_CT, 32'h3, 4'b0001);
    rd(A_ST, v);
    checks++;
    if (v !== st_exp(0, 0, 1)) begin
      errors++;
      $display("FAIL flush_status got %h want %h", v, st_exp(0, 0, 1));
    end
    rd(A_CT, v);
    checks++;
    if (v !== 32'h1) begin
      errors++;
      $display("FAIL flush_ctrl got %h want 1", v);
    end
    for (int j = 3; j < 40; j++) begin
      step();
      act[j] = tx;
    end
    checks++;
    if (act[39:3] !== exp[39:3]) begin
      errors++;
      $display("FAIL flush_frame got %h want %h", act[39:3], exp[39:3]);
    end
    for (int j = 0; j < 61; j++) begin
      step();
      idle[j] = tx;
    end
    checks++;
    if (idle !== {61{1'b1}}) begin
      errors++;
      $display("FAIL flush_idle got %h want all ones", idle);
    end
    rd(A_ST, v);
    checks++;
    if (v !== st_exp(0, 0, 0)) begin
      errors++;
      $display("FAIL flush_end got %h want %h", v, st_exp(0, 0, 0));
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    logic [7:0] a;
    logic [49:0] idle;
    a = 8'($urandom) & 8'hFE;
    wr(A_TX, {24'h0, a}, 4'b0001);
    wr(A_TX, $urandom, 4'b0001);
    wr(A_TX, $urandom, 4'b0001);
    for (int j = 2; j <= 5; j++) step();
    checks++;
    if (tx !== 1'b0) begin
      errors++;
      $display("FAIL rmid_data0 got %b want 0", tx);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1) begin
      errors++;
      $display("FAIL rmid_async_tx got %b want 1", tx);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    ovf_m = 1'b0;
    step();
    rd(A_ST, v);
    checks++;
    if (v !== st_exp(0, 0, 0)) begin
      errors++;
      $display("FAIL rmid_status got %h want %h", v, st_exp(0, 0, 0));
    end
    rd(A_CT, v);
    checks++;
    if (v !== 32'h1) begin
      errors++;
      $display("FAIL rmid_ctrl got %h want 1", v);
    end
    for (int j = 0; j < 50; j++) begin
      step();
      idle[j] = tx;
    end
    checks++;
    if (idle !== {50{1'b1}}) begin
      errors++;
      $display("FAIL rmid_idle got %h want all ones", idle);
    end
  endtask

  initial begin
    bus.ram_r    = 1'b0;
    bus.ram_w    = 4'h0;
    bus.ram_addr = 32'h0;
    bus.ram_out  = 32'h0;
    test_reset();
    test_lane_miss();
    test_single();
    test_overflow();
    test_drain();
    test_status_random();
    test_flush_mid();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
